// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ID/EX payload used by the operand-fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ILEN   = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } of_state_e;

    typedef struct packed {
        logic [ILEN-1:0]   instr;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

    // Only U/J-type formats lack an rs1 field.
    function automatic logic op_uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use interlock: flags an instruction whose source registers match a pending load.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic [ILEN-1:0]   in_instr,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    output logic              use_rs1,
    output logic              use_rs2,
    output logic              stall
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              unused_bits;

    assign opcode      = in_instr[6:0];
    assign rs1         = in_instr[19:15];
    assign rs2         = in_instr[24:20];
    assign unused_bits = ^{in_instr[31:25], in_instr[14:7]};

    assign use_rs1 = op_uses_rs1(opcode);
    assign use_rs2 = op_uses_rs2(opcode);

    // A load into x0 never produces a dependency.
    assign stall = ld_valid && (ld_rd != '0)
                 && ((use_rs1 && (ld_rd == rs1)) || (use_rs2 && (ld_rd == rs2)));

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register read, execute bypass, load-use interlock, ID/EX register.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rf_a1,
    output logic [REG_AW-1:0] rf_a2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              byp_valid,
    input  logic [REG_AW-1:0] byp_rd,
    input  logic [XLEN-1:0]   byp_data,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ILEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1,
    output logic [XLEN-1:0]   out_rs2,
    output logic [REG_AW-1:0] out_rd
);

    of_state_e state_q, state_d;
    idex_t     idex_q, idex_d;
    logic      hz_stall;
    logic      use_rs1;
    logic      use_rs2;
    logic      unused_use;
    logic      accept;

    hazard_unit u_hazard (
        .in_instr (in_instr),
        .ld_valid (ld_valid),
        .ld_rd    (ld_rd),
        .use_rs1  (use_rs1),
        .use_rs2  (use_rs2),
        .stall    (hz_stall)
    );

    assign unused_use = use_rs1 ^ use_rs2;

    assign rf_a1 = in_instr[19:15];
    assign rf_a2 = in_instr[24:20];

    // The register file writes on negedge, so only execute needs a bypass path.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_val,
        input logic              bv,
        input logic [REG_AW-1:0] brd,
        input logic [XLEN-1:0]   bdata
    );
        if (addr == '0)                 return '0;
        else if (bv && (brd == addr))   return bdata;
        else                            return rf_val;
    endfunction

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !flush && !hz_stall && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Next state and next payload.
    always_comb begin
        state_d      = state_q;
        idex_d       = idex_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
        if (accept) begin
            idex_d.instr = in_instr;
            idex_d.pc    = in_pc;
            idex_d.rs1   = resolve(in_instr[19:15], rf_rd1, byp_valid, byp_rd, byp_data);
            idex_d.rs2   = resolve(in_instr[24:20], rf_rd2, byp_valid, byp_rd, byp_data);
            idex_d.rd    = in_instr[11:7];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idex_q  <= '{instr: NOP_INSTR, default: '0};
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    assign out_instr = idex_q.instr;
    assign out_pc    = idex_q.pc;
    assign out_rs1   = idex_q.rs1;
    assign out_rs2   = idex_q.rs2;
    assign out_rd    = idex_q.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized bench for operand_fetch against a behavioural stage model.
module tb_operand_fetch;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr, out_pc, out_rs1, out_rs2;
    logic [4:0]  out_rd;

    always #5 CLK = ~CLK;

    operand_fetch dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .byp_valid(byp_valid), .byp_rd(byp_rd),
        .byp_data(byp_data), .ld_valid(ld_valid), .ld_rd(ld_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd)
    );

    // Register file contents as the bench sees them; x0 deliberately holds junk.
    logic [31:0] rf [32];
    assign rf_rd1 = rf[in_instr[19:15]];
    assign rf_rd2 = rf[in_instr[24:20]];

    int checks = 0;
    int errors = 0;

    // Reference stage contents.
    logic        ev;
    logic [31:0] ei, ep, e1, e2;
    logic [4:0]  erd;

    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op == 7'h33 || op == 7'h23 || op == 7'h63;
    endfunction

    function automatic logic load_use(input logic [31:0] ins, input logic lv, input logic [4:0] lrd);
        if (!lv || lrd == 5'd0) return 1'b0;
        return (reads_rs1(ins[6:0]) && lrd == ins[19:15]) || (reads_rs2(ins[6:0]) && lrd == ins[24:20]);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp_valid && byp_rd == a) return byp_data;
        return rf[a];
    endfunction

    function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        return {7'd0, s2, s1, 3'd0, rd, 7'h33};
    endfunction

    task automatic model_reset();
        ev = 1'b0; ei = 32'h13; ep = '0; e1 = '0; e2 = '0; erd = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_instr", out_instr, ei);
        chk("out_pc", out_pc, ep);
        chk("out_rs1", out_rs1, e1);
        chk("out_rs2", out_rs2, e2);
        chk("out_rd", 32'(out_rd), 32'(erd));
    endtask

    task automatic offer(input logic iv, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = iv; in_instr = ins; in_pc = pc;
    endtask

    // One cycle: inputs already driven after a negedge; check, clock, update model, check.
    task automatic tick();
        logic exp_rdy;
        logic acc;
        #1;
        exp_rdy = !flush && !load_use(in_instr, ld_valid, ld_rd) && (!ev || out_ready);
        if (in_valid) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("rf_a1", 32'(rf_a1), 32'(in_instr[19:15]));
        chk("rf_a2", 32'(rf_a2), 32'(in_instr[24:20]));
        acc = in_valid && exp_rdy;
        @(posedge CLK);
        if (acc) begin
            ei = in_instr; ep = in_pc; erd = in_instr[11:7];
            e1 = operand(in_instr[19:15]);
            e2 = operand(in_instr[24:20]);
        end
        if (flush) ev = 1'b0;
        else if (acc) ev = 1'b1;
        else if (ev && out_ready) ev = 1'b0;
        #1;
        check_outputs();
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0;
        offer(1'b0, 32'h13, '0);
        byp_valid = 1'b0; byp_rd = '0; byp_data = '0;
        ld_valid = 1'b0; ld_rd = '0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'h5555_5555;
        model_reset();
        #12;
        check_outputs();
        @(negedge CLK);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Plain register read.
        rf[5] = 32'h1234; rf[6] = 32'h10;
        offer(1'b1, mk_add(5'd7, 5'd5, 5'd6), 32'h100);
        tick();
        chk("add_rs1", out_rs1, 32'h1234);
        chk("add_rd", 32'(out_rd), 32'd7);

        // Execute bypass, and x0 wins over a bypass to x0.
        byp_valid = 1'b1; byp_rd = 5'd5; byp_data = 32'hDEAD;
        tick();
        chk("byp_rs1", out_rs1, 32'hDEAD);
        byp_rd = 5'd0;
        offer(1'b1, mk_add(5'd7, 5'd0, 5'd6), 32'h104);
        tick();
        chk("x0_rs1", out_rs1, 32'd0);
        byp_valid = 1'b0;

        // Load-use stall held for three cycles, then release.
        ld_valid = 1'b1; ld_rd = 5'd5;
        offer(1'b1, mk_add(5'd8, 5'd5, 5'd6), 32'h108);
        for (int i = 0; i < 3; i++) tick();
        ld_valid = 1'b0;
        tick();
        // LUI whose immediate aliases rs1/rs2 = x5 must not stall.
        ld_valid = 1'b1;
        offer(1'b1, {7'd0, 5'd5, 5'd5, 3'd0, 5'd5, 7'h37}, 32'h10c);
        tick();
        ld_valid = 1'b0;

        // Back-pressure: stage full, execute not ready.
        out_ready = 1'b0;
        offer(1'b1, mk_add(5'd9, 5'd1, 5'd2), 32'h200);
        tick();
        offer(1'b1, mk_add(5'd10, 5'd3, 5'd4), 32'h204);
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1;
        tick();
        offer(1'b0, 32'h13, '0);
        tick();

        // Flush while full with a pending input.
        out_ready = 1'b0;
        offer(1'b1, mk_add(5'd11, 5'd1, 5'd3), 32'h300);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        offer(1'b1, mk_add(5'd12, 5'd2, 5'd3), 32'h304);
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h13, '0);
        tick();

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        offer(1'b1, mk_add(5'd13, 5'd4, 5'd5), 32'h400);
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(1'b0, 32'h13, '0);
        tick();

        // Randomized traffic with a small register window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 8)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            offer($urandom_range(0, 99) < 75, ins, $urandom);
            out_ready = $urandom_range(0, 99) < 70;
            flush     = $urandom_range(0, 99) < 8;
            byp_valid = $urandom_range(0, 1) == 1;
            byp_rd    = 5'($urandom_range(0, 7));
            byp_data  = $urandom;
            ld_valid  = $urandom_range(0, 99) < 30;
            ld_rd     = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 7)] = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
